// File: rtl/keypoint_pkg.sv
`default_nettype none
// ============================================================================
// Package     : keypoint_pkg
// Description : Types and constants shared by the keypoint fetch stage and
//               its output buffer. Holds the 21-bit SRAM entry layout, the
//               default list and image limits, the fetch FSM encoding and a
//               count-clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package keypoint_pkg;

    // Entry layout as stored in the keypoint SRAMs; bits [20:19] are reserved.
    localparam int KP_W       = 21;
    localparam int KP_ROW_MSB = 18;
    localparam int KP_ROW_LSB = 10;
    localparam int KP_COL_MSB = 9;
    localparam int KP_COL_LSB = 0;
    localparam int KP_ROW_W   = KP_ROW_MSB - KP_ROW_LSB + 1;
    localparam int KP_COL_W   = KP_COL_MSB - KP_COL_LSB + 1;

    // Count/address width and the packed {layer, row, col} buffer word.
    localparam int KP_CNT_W = 11;
    localparam int KP_OUT_W = 1 + KP_ROW_W + KP_COL_W;

    // Default list capacity and image geometry.
    localparam int MAX_KP   = 2000;
    localparam int IMG_ROWS = 480;
    localparam int IMG_COLS = 640;
    localparam int BORDER   = 8;

    // Fetch FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RD1   = 2'd1;
    localparam state_t ST_RD2   = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    // Limit a requested entry count to the SRAM capacity.
    function automatic logic [KP_CNT_W-1:0] clamp_count(
        input logic [KP_CNT_W-1:0] count,
        input logic [KP_CNT_W-1:0] limit
    );
        return (count > limit) ? limit : count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kp_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kp_out_fifo
// Description : Two-entry synchronous FIFO with a valid/ready read side.
//               The head word stays stable until it is popped. Occupancy is
//               exported so an upstream reader can budget its SRAM reads.
// Ports       : clk, rst_n        clock, asynchronous active-low reset
//               i_push, i_data    write strobe and word
//               o_valid, i_ready  read-side handshake
//               o_data            head word
//               o_occupancy       stored words (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module kp_out_fifo
    import keypoint_pkg::*;
#(
    parameter int WIDTH = KP_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_occupancy
);

    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_pop;
    logic             w_wr;

    always_comb begin
        w_pop = (r_count != 2'd0) && i_ready;
        // A push into a full buffer is only honoured when the head leaves
        // in the same cycle.
        w_wr  = i_push && ((r_count != 2'd2) || w_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid     = (r_count != 2'd0);
    assign o_data      = r_mem[r_rd_ptr];
    assign o_occupancy = r_count;

endmodule
`default_nettype wire

// File: rtl/keypoint_fetch.sv
`default_nettype none
// ============================================================================
// Module      : keypoint_fetch
// Description : Reads keypoint SRAM 1 then SRAM 2, unpacks each entry into
//               row/col and streams one keypoint per transfer downstream
//               through a two-entry buffer. SRAM reads are issued only when
//               the buffer is guaranteed to have room for the returning word.
// Ports       : clk, rst_n                  clock, async active-low reset
//               start, kp1_count, kp2_count  run request and list lengths
//               keypoint_{1,2}_addr/_dout    SRAM read ports (1-cycle latency)
//               kp_valid, kp_ready           downstream handshake
//               kp_row, kp_col, kp_layer     keypoint payload
//               busy, done, kp_emitted       run status
//               kp_dropped                   border-rejected entries (option)
// Options     : KP_BORDER_FILTER_EN - drop entries within BORDER pixels of
//               the image edge and add the kp_dropped port.
// Revision    : 1.0 - initial release
// ============================================================================
module keypoint_fetch
    import keypoint_pkg::*;
#(
    parameter int MAX_KP   = keypoint_pkg::MAX_KP,
    parameter int IMG_ROWS = keypoint_pkg::IMG_ROWS,
    parameter int IMG_COLS = keypoint_pkg::IMG_COLS,
    parameter int BORDER   = keypoint_pkg::BORDER
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KP_CNT_W-1:0] kp1_count,
    input  logic [KP_CNT_W-1:0] kp2_count,
    output logic [KP_CNT_W-1:0] keypoint_1_addr,
    input  logic [KP_W-1:0]     keypoint_1_dout,
    output logic [KP_CNT_W-1:0] keypoint_2_addr,
    input  logic [KP_W-1:0]     keypoint_2_dout,
    output logic                kp_valid,
    input  logic                kp_ready,
    output logic [KP_ROW_W-1:0] kp_row,
    output logic [KP_COL_W-1:0] kp_col,
    output logic                kp_layer,
    output logic                busy,
    output logic                done,
`ifdef KP_BORDER_FILTER_EN
    output logic [11:0]         kp_dropped,
`endif
    output logic [11:0]         kp_emitted
);

    localparam bit c_filter_en =
`ifdef KP_BORDER_FILTER_EN
        1'b1;
`else
        1'b0;
`endif

    localparam logic [KP_CNT_W-1:0] c_max_kp   = KP_CNT_W'(MAX_KP);
    localparam logic [11:0]         c_emit_max = 12'(2 * MAX_KP);
    localparam logic [KP_ROW_W-1:0] c_row_lo   = KP_ROW_W'(BORDER);
    localparam logic [KP_ROW_W-1:0] c_row_hi   = KP_ROW_W'(IMG_ROWS - BORDER);
    localparam logic [KP_COL_W-1:0] c_col_lo   = KP_COL_W'(BORDER);
    localparam logic [KP_COL_W-1:0] c_col_hi   = KP_COL_W'(IMG_COLS - BORDER);

    function automatic logic in_frame(
        input logic [KP_ROW_W-1:0] row,
        input logic [KP_COL_W-1:0] col
    );
        return (row >= c_row_lo) && (row < c_row_hi) &&
               (col >= c_col_lo) && (col < c_col_hi);
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [KP_CNT_W-1:0]   r_cnt1;
    logic [KP_CNT_W-1:0]   r_cnt2;
    logic [KP_CNT_W-1:0]   r_addr1;
    logic [KP_CNT_W-1:0]   r_addr2;
    logic                  r_rd_vld;
    logic                  r_rd_layer;
    logic                  r_busy;
    logic                  r_done;
    logic [11:0]           r_emitted;

    logic                  w_accept;
    logic                  w_issue1;
    logic                  w_issue2;
    logic                  w_finish;
    logic                  w_last1;
    logic                  w_last2;
    logic                  w_credit;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_keep;
    logic [2:0]            w_occ_net;
    logic [1:0]            w_occ;
    logic [KP_W-1:0]       w_rd_data;
    logic [KP_ROW_W-1:0]   w_row;
    logic [KP_COL_W-1:0]   w_col;
    logic [KP_OUT_W-1:0]   w_fifo_out;
    logic                  w_unused_reserved;

    // ------------------------------------------------------------------
    // Returning read data and the push into the output buffer
    // ------------------------------------------------------------------
    assign w_rd_data = r_rd_layer ? keypoint_2_dout : keypoint_1_dout;
    assign w_row     = w_rd_data[KP_ROW_MSB:KP_ROW_LSB];
    assign w_col     = w_rd_data[KP_COL_MSB:KP_COL_LSB];
    assign w_keep    = !c_filter_en || in_frame(w_row, w_col);
    assign w_push    = r_rd_vld && w_keep;
    // Reserved entry bits carry no information for this stage.
    assign w_unused_reserved = ^w_rd_data[KP_W-1:KP_ROW_MSB+1];

    assign w_pop = kp_valid && kp_ready;

    // Words that will occupy the buffer once this cycle settles: stored
    // words, plus the read returning now, minus the word leaving now.
    // Counting the departing word keeps a full-rate stream with ready high.
    assign w_occ_net = {1'b0, w_occ} + {2'b00, r_rd_vld} - {2'b00, w_pop};
    assign w_credit  = (w_occ_net < 3'd2);

    assign w_last1 = (r_addr1 == r_cnt1 - KP_CNT_W'(1));
    assign w_last2 = (r_addr2 == r_cnt2 - KP_CNT_W'(1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue1    = 1'b0;
        w_issue2    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (clamp_count(kp1_count, c_max_kp) == '0) ? ST_RD2 : ST_RD1;
                end
            end
            ST_RD1: begin
                if (w_credit) begin
                    w_issue1 = 1'b1;
                    if (w_last1) begin
                        w_state_nxt = (r_cnt2 == '0) ? ST_DRAIN : ST_RD2;
                    end
                end
            end
            ST_RD2: begin
                if (r_cnt2 == '0) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_credit) begin
                    w_issue2 = 1'b1;
                    if (w_last2) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!r_rd_vld && (w_occ == 2'd0)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Run bookkeeping, address generation and read tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt1     <= '0;
            r_cnt2     <= '0;
            r_addr1    <= '0;
            r_addr2    <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_layer <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_emitted  <= '0;
        end else begin
            r_done     <= w_finish;
            r_rd_vld   <= w_issue1 || w_issue2;
            r_rd_layer <= w_issue2;

            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (w_finish) begin
                r_busy <= 1'b0;
            end

            if (w_accept) begin
                r_cnt1    <= clamp_count(kp1_count, c_max_kp);
                r_cnt2    <= clamp_count(kp2_count, c_max_kp);
                r_addr1   <= '0;
                r_addr2   <= '0;
                r_emitted <= '0;
            end else begin
                // Addresses park on the last entry so they never leave
                // the valid range of the list.
                if (w_issue1 && !w_last1) begin
                    r_addr1 <= r_addr1 + KP_CNT_W'(1);
                end
                if (w_issue2 && !w_last2) begin
                    r_addr2 <= r_addr2 + KP_CNT_W'(1);
                end
                if (w_pop && (r_emitted != c_emit_max)) begin
                    r_emitted <= r_emitted + 12'd1;
                end
            end
        end
    end

`ifdef KP_BORDER_FILTER_EN
    logic [11:0] r_dropped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dropped <= '0;
        end else if (w_accept) begin
            r_dropped <= '0;
        end else if (r_rd_vld && !w_keep) begin
            r_dropped <= r_dropped + 12'd1;
        end
    end

    assign kp_dropped = r_dropped;
`endif

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    kp_out_fifo #(
        .WIDTH (KP_OUT_W)
    ) u_out_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_data      ({r_rd_layer, w_row, w_col}),
        .o_valid     (kp_valid),
        .i_ready     (kp_ready),
        .o_data      (w_fifo_out),
        .o_occupancy (w_occ)
    );

    assign {kp_layer, kp_row, kp_col} = w_fifo_out;
    assign keypoint_1_addr = r_addr1;
    assign keypoint_2_addr = r_addr2;
    assign busy            = r_busy;
    assign done            = r_done;
    assign kp_emitted      = r_emitted;

endmodule
`default_nettype wire

// File: tb/tb_keypoint_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypoint_fetch
// Description : Self-checking bench for keypoint_fetch. SRAM contents are
//               randomised; the expected keypoint stream is derived from the
//               list contents, clamped counts and (optionally) the border
//               rule, then compared transfer by transfer.
// Options     : KP_BORDER_FILTER_EN - same meaning as in the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypoint_fetch;

    localparam int  MAX_ENTRIES = 2000;
`ifdef KP_BORDER_FILTER_EN
    localparam bit  FILTER_ON = 1'b1;
`else
    localparam bit  FILTER_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] kp1_count;
    logic [10:0] kp2_count;
    logic [10:0] keypoint_1_addr;
    logic [20:0] keypoint_1_dout;
    logic [10:0] keypoint_2_addr;
    logic [20:0] keypoint_2_dout;
    logic        kp_valid;
    logic        kp_ready;
    logic [8:0]  kp_row;
    logic [9:0]  kp_col;
    logic        kp_layer;
    logic        busy;
    logic        done;
    logic [11:0] kp_emitted;
`ifdef KP_BORDER_FILTER_EN
    logic [11:0] kp_dropped;
`endif

    logic [20:0] mem1 [0:2047];
    logic [20:0] mem2 [0:2047];
    logic [19:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Synchronous-read SRAM models: data follows the address by one cycle.
    always @(posedge clk) begin
        keypoint_1_dout <= mem1[keypoint_1_addr];
        keypoint_2_dout <= mem2[keypoint_2_addr];
    end

    keypoint_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .kp1_count       (kp1_count),
        .kp2_count       (kp2_count),
        .keypoint_1_addr (keypoint_1_addr),
        .keypoint_1_dout (keypoint_1_dout),
        .keypoint_2_addr (keypoint_2_addr),
        .keypoint_2_dout (keypoint_2_dout),
        .kp_valid        (kp_valid),
        .kp_ready        (kp_ready),
        .kp_row          (kp_row),
        .kp_col          (kp_col),
        .kp_layer        (kp_layer),
        .busy            (busy),
        .done            (done),
`ifdef KP_BORDER_FILTER_EN
        .kp_dropped      (kp_dropped),
`endif
        .kp_emitted      (kp_emitted)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit keep_entry(input logic [20:0] e);
        int r;
        int c;
        r = int'(e[18:10]);
        c = int'(e[9:0]);
        return !FILTER_ON || (r >= 8 && r < 472 && c >= 8 && c < 632);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 2048; i++) begin
            mem1[i] = 21'($urandom());
            mem2[i] = 21'($urandom());
        end
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic run_case(input string name, input int c1, input int c2, input int mode);
        int n1, n2, n_exp, n_drop, k, budget, first_k, last_k, done_k, max1, max2;
        logic        prev_stall;
        logic [19:0] prev_data;
        logic [19:0] got;
        logic [20:0] e;
        logic        pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        exp_q.delete();
        n_drop = 0;
        n1 = (c1 > MAX_ENTRIES) ? MAX_ENTRIES : c1;
        n2 = (c2 > MAX_ENTRIES) ? MAX_ENTRIES : c2;
        for (int i = 0; i < n1; i++) begin
            e = mem1[i];
            if (keep_entry(e)) exp_q.push_back({1'b0, e[18:10], e[9:0]});
            else n_drop++;
        end
        for (int i = 0; i < n2; i++) begin
            e = mem2[i];
            if (keep_entry(e)) exp_q.push_back({1'b1, e[18:10], e[9:0]});
            else n_drop++;
        end
        n_exp  = exp_q.size();
        budget = 4 * (n1 + n2) + 40;

        @(negedge clk);
        kp1_count = 11'(c1);
        kp2_count = 11'(c2);
        start     = 1'b1;
        first_k = -1; last_k = -1; done_k = -1; max1 = 0; max2 = 0;
        prev_stall = 1'b0; prev_data = '0;
        k = 0;
        while (k < budget && done_k < 0) begin
            k++;
            @(negedge clk);
            start = 1'b0;
            case (mode)
                0:       kp_ready = 1'b1;
                1:       kp_ready = pat[(k - 1) % 4];
                default: kp_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (int'(keypoint_1_addr) > max1) max1 = int'(keypoint_1_addr);
            if (int'(keypoint_2_addr) > max2) max2 = int'(keypoint_2_addr);
            got = {kp_layer, kp_row, kp_col};
            if (prev_stall)
                check_eq($sformatf("%s:hold", name), {11'd0, kp_valid, got}, {11'd0, 1'b1, prev_data});
            if (kp_valid && kp_ready) begin
                if (first_k < 0) first_k = k;
                last_k = k;
                if (exp_q.size() == 0)
                    check_eq($sformatf("%s:extra", name), {31'd0, kp_valid}, 32'd0);
                else
                    check_eq($sformatf("%s:data", name), {12'd0, got}, {12'd0, exp_q.pop_front()});
            end
            prev_stall = kp_valid && !kp_ready;
            prev_data  = got;
            if (done) done_k = k;
        end

        check_eq($sformatf("%s:done", name), {31'd0, done}, 32'd1);
        check_eq($sformatf("%s:remaining", name), exp_q.size(), 32'd0);
        check_eq($sformatf("%s:emitted", name), {20'd0, kp_emitted}, n_exp);
        if (n1 > 0) check_eq($sformatf("%s:max_addr1", name), max1, n1 - 1);
        if (n2 > 0) check_eq($sformatf("%s:max_addr2", name), max2, n2 - 1);
        if (mode == 0 && n_exp > 0 && n_drop == 0) begin
            check_eq($sformatf("%s:first_valid", name), first_k, 32'd3);
            check_eq($sformatf("%s:back_to_back", name), last_k - first_k, n_exp - 1);
        end
        if (n1 + n2 == 0)
            check_eq($sformatf("%s:done_latency", name), done_k, 32'd3);
`ifdef KP_BORDER_FILTER_EN
        check_eq($sformatf("%s:dropped", name), {20'd0, kp_dropped}, n_drop);
`endif
        @(negedge clk);
        #1;
        check_eq($sformatf("%s:done_pulse", name), {31'd0, done}, 32'd0);
        check_eq($sformatf("%s:busy_after", name), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        kp_ready  = 1'b0;
        kp1_count = '0;
        kp2_count = '0;
        fill_random();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_eq("reset:valid", {31'd0, kp_valid}, 32'd0);
        check_eq("reset:busy", {31'd0, busy}, 32'd0);
        check_eq("reset:done", {31'd0, done}, 32'd0);
        check_eq("reset:emitted", {20'd0, kp_emitted}, 32'd0);
        check_eq("reset:addr", {10'd0, keypoint_1_addr, keypoint_2_addr}, 32'd0);

        run_case("basic", 3, 2, 0);
        run_case("stall", 4, 0, 1);
        run_case("empty", 0, 0, 0);
        run_case("only2", 0, 5, 2);

        // Border-rule entries: only (200,300) survives when filtering.
        mem1[0] = {2'b11, 9'd3,   10'd100};
        mem1[1] = {2'b00, 9'd200, 10'd635};
        mem1[2] = {2'b10, 9'd200, 10'd300};
        run_case("border", 3, 0, 0);

        fill_random();
        run_case("clamp", 2047, 3, 0);

        // Reset in the middle of RD1 with the buffer holding two entries.
        @(negedge clk);
        kp_ready  = 1'b0;
        kp1_count = 11'd10;
        kp2_count = 11'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check_eq("midrst:valid_before", {31'd0, kp_valid}, 32'd1);
        check_eq("midrst:addr_before", {21'd0, keypoint_1_addr}, 32'd2);
        rst_n = 1'b0;
        #1;
        check_eq("midrst:valid", {31'd0, kp_valid}, 32'd0);
        check_eq("midrst:addr", {21'd0, keypoint_1_addr}, 32'd0);
        check_eq("midrst:busy", {31'd0, busy}, 32'd0);
        check_eq("midrst:payload", {12'd0, kp_layer, kp_row, kp_col}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_case("after_rst", 10, 0, 0);

        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_case($sformatf("rand%0d", r), int'($urandom_range(0, 24)),
                     int'($urandom_range(0, 24)), (r == 0) ? 1 : 2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
